// File: rtl/scramble_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : scramble_pkg
//  Purpose : Shared definitions for the pad-keyed scrambler family. It holds
//            the LFSR tap mask, the word width, the single-step LFSR function
//            and the checker state encoding.
//  Ports   : n/a (package)
//  Rev     : 1.0  initial release
// ============================================================================
package scramble_pkg;

  localparam int WORD_W = 32;
  localparam int PAD_W  = 16;

  // Bit 0 of the mask is clear, so the injected pad bit is never disturbed
  // by the feedback term.
  localparam logic [WORD_W-1:0] TAP_MASK = 32'h82F63B78;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One scrambler step: shift left, inject the pad bit at bit 0, and fold in
  // the tap mask when the bit shifted out was set.
  function automatic logic [WORD_W-1:0] lfsr_step(input logic [WORD_W-1:0] x,
                                                  input logic              p);
    return {x[WORD_W-2:0], p} ^ ({WORD_W{x[WORD_W-1]}} & TAP_MASK);
  endfunction

endpackage : scramble_pkg
`default_nettype wire

// File: rtl/scramble_checker_if.sv
`default_nettype none
// ============================================================================
//  Module  : scramble_checker_if
//  Purpose : Request/result bundle for the scramble checker.
//  Signals : pushin  - accept request (sampled while ready=1)
//            din     - received scrambled word
//            cand    - candidate data-plus-entropy word
//            pad_key - pad key used by the scrambler
//            ready   - checker can accept pushin
//            pushout - one-cycle result strobe
//            match   - re-scrambled cand equals din (held between results)
//            err_cnt - saturating mismatch count
//  Modports: master (request source), slave (checker)
//  Rev     : 1.0  initial release
// ============================================================================
interface scramble_checker_if #(
  parameter int ERRW = 16
);
  logic            pushin;
  logic [31:0]     din;
  logic [31:0]     cand;
  logic [15:0]     pad_key;
  logic            ready;
  logic            pushout;
  logic            match;
  logic [ERRW-1:0] err_cnt;

  modport master (
    output pushin, din, cand, pad_key,
    input  ready, pushout, match, err_cnt
  );

  modport slave (
    input  pushin, din, cand, pad_key,
    output ready, pushout, match, err_cnt
  );
endinterface : scramble_checker_if
`default_nettype wire

// File: rtl/scramble_checker.sv
`default_nettype none
// ============================================================================
//  Module  : scramble_checker
//  Purpose : Receive-side check for the pad-keyed scrambler. The scrambler
//            step drops one bit per step, so it cannot be inverted; instead a
//            candidate word is re-scrambled one LFSR step per clock and the
//            result is compared against the received scrambled word.
//  Ports   : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - scramble_checker_if.slave (pushin/din/cand/pad_key in,
//                   ready/pushout/match/err_cnt out)
//  Params  : NSTEP - LFSR steps per word (1..16), uses pad_key[NSTEP-1:0]
//            ERRW  - mismatch counter width (must equal the interface ERRW)
//  Rev     : 1.0  initial release
// ============================================================================
module scramble_checker
  import scramble_pkg::*;
#(
  parameter int NSTEP = 16,
  parameter int ERRW  = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  scramble_checker_if.slave bus
);

  localparam int                CNT_W    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NSTEP - 1);
  localparam logic [ERRW-1:0]   ERR_MAX  = '1;

  state_t              r_state,   w_state_nxt;
  logic [WORD_W-1:0]   r_lfsr,    w_lfsr_nxt;
  logic [WORD_W-1:0]   r_din_q,   w_din_nxt;
  logic [PAD_W-1:0]    r_pad_q,   w_pad_nxt;
  logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
  logic                r_ready,   w_ready_nxt;
  logic                r_pushout, w_pushout_nxt;
  logic                r_match,   w_match_nxt;
  logic [ERRW-1:0]     r_err_cnt, w_err_nxt;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lfsr    <= '0;
      r_din_q   <= '0;
      r_pad_q   <= '0;
      r_cnt     <= '0;
      r_ready   <= 1'b1;
      r_pushout <= 1'b0;
      r_match   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_din_q   <= w_din_nxt;
      r_pad_q   <= w_pad_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ready   <= w_ready_nxt;
      r_pushout <= w_pushout_nxt;
      r_match   <= w_match_nxt;
      r_err_cnt <= w_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_din_nxt   = r_din_q;
    w_pad_nxt   = r_pad_q;
    w_cnt_nxt   = r_cnt;
    w_match_nxt = r_match;
    w_err_nxt   = r_err_cnt;

    unique case (r_state)
      // DONE accepts a new word exactly like IDLE, which gives back-to-back
      // throughput of one word per NSTEP+2 cycles.
      IDLE, DONE: begin
        if (bus.pushin) begin
          w_lfsr_nxt  = bus.cand;
          w_din_nxt   = bus.din;
          w_pad_nxt   = bus.pad_key;
          w_cnt_nxt   = '0;
          w_state_nxt = STEP;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      STEP: begin
        w_lfsr_nxt = lfsr_step(r_lfsr, r_pad_q[r_cnt]);
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = CHECK;
        end
      end

      CHECK: begin
        w_match_nxt = (r_lfsr == r_din_q);
        if ((r_lfsr != r_din_q) && (r_err_cnt != ERR_MAX)) begin
          w_err_nxt = r_err_cnt + 1'b1;
        end
        w_state_nxt = DONE;
      end

      default: w_state_nxt = IDLE;
    endcase

    // ready/pushout are registered from the next state so the outputs come
    // straight off flops.
    w_ready_nxt   = (w_state_nxt == IDLE) || (w_state_nxt == DONE);
    w_pushout_nxt = (w_state_nxt == DONE);
  end

  assign bus.ready   = r_ready;
  assign bus.pushout = r_pushout;
  assign bus.match   = r_match;
  assign bus.err_cnt = r_err_cnt;

endmodule : scramble_checker
`default_nettype wire

// File: tb/tb_scramble_checker.sv
`default_nettype none
// ============================================================================
//  Module  : tb_scramble_checker
//  Purpose : Self-checking bench for scramble_checker. A second instance with
//            a 2-bit counter shares the stimulus to exercise saturation.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_scramble_checker;
  import scramble_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scramble_checker_if #(.ERRW(16)) bus  ();
  scramble_checker_if #(.ERRW(2))  bus2 ();

  assign bus2.pushin  = bus.pushin;
  assign bus2.din     = bus.din;
  assign bus2.cand    = bus.cand;
  assign bus2.pad_key = bus.pad_key;

  scramble_checker #(.NSTEP(16), .ERRW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  scramble_checker #(.NSTEP(16), .ERRW(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_match;
  int   err_exp  = 0;
  int   err2_exp = 0;

  // Reference: the word viewed as an unbounded integer is doubled with the
  // pad bit added; any overflow past 2^32 is removed and the tap mask folded in.
  function automatic logic [31:0] model_scramble(input logic [31:0] c,
                                                 input logic [15:0] pad,
                                                 input int          n);
    longint unsigned v;
    v = longint'(c);
    for (int i = 0; i < n; i++) begin
      v = v * 2 + longint'(pad[i]);
      if (v >= 64'h1_0000_0000) v = (v - 64'h1_0000_0000) ^ longint'(TAP_MASK);
    end
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request and let the acceptance edge (E0) pass.
  task automatic accept(input logic [31:0] c, input logic [31:0] d, input logic [15:0] p);
    int w;
    w = 0;
    while (!bus.ready && w < 40) begin
      tick();
      w++;
    end
    if (w >= 40) chk("ready_timeout", 64'd0, 64'd1);
    exp_match   = (d == model_scramble(c, p, 16));
    bus.pushin  = 1'b1;
    bus.cand    = c;
    bus.din     = d;
    bus.pad_key = p;
    tick();
    bus.pushin  = 1'b0;
  endtask

  // Wait for the result strobe; 'start' is the cycles already elapsed since E0.
  task automatic wait_result(input int start);
    int k;
    k = start;
    while (!bus.pushout && k < 40) begin
      tick();
      k++;
    end
    if (!exp_match) begin
      err_exp  = (err_exp  < 65535) ? err_exp + 1  : err_exp;
      err2_exp = (err2_exp < 3)     ? err2_exp + 1 : err2_exp;
    end
    chk("latency",  64'(k), 64'd17);
    chk("match",    64'(bus.match), 64'(exp_match));
    chk("err_cnt",  64'(bus.err_cnt), 64'(err_exp));
    chk("pushout2", 64'(bus2.pushout), 64'd1);
    chk("err_cnt2", 64'(bus2.err_cnt), 64'(err2_exp));
    tick();
    chk("pushout_one_cycle", 64'(bus.pushout), 64'd0);
  endtask

  task automatic do_word(input logic [31:0] c, input logic [31:0] d, input logic [15:0] p);
    accept(c, d, p);
    wait_result(0);
  endtask

  initial begin
    logic [31:0] c, d, m;
    logic [15:0] p;
    int          npush, first, k;

    rst = 1'b1;
    bus.pushin = 1'b0; bus.din = '0; bus.cand = '0; bus.pad_key = '0;
    tick(); tick();

    // Reset state
    chk("rst_ready",   64'(bus.ready),    64'd1);
    chk("rst_pushout", 64'(bus.pushout),  64'd0);
    chk("rst_match",   64'(bus.match),    64'd0);
    chk("rst_err",     64'(bus.err_cnt),  64'd0);
    chk("rst_err2",    64'(bus2.err_cnt), 64'd0);
    rst = 1'b0;
    tick();

    // Pad only
    do_word(32'h0000_0000, 32'h0000_8000, 16'h0001);
    // No-feedback path: match, then a one-bit mismatch
    do_word(32'h0000_1234, 32'h1234_8000, 16'h0001);
    do_word(32'h0000_1234, 32'h1234_8001, 16'h0001);

    // Four more mismatches: small counter goes 2,3,3,3
    for (int i = 0; i < 4; i++) begin
      c = $urandom; p = 16'($urandom);
      do_word(c, model_scramble(c, p, 16) ^ 32'h0000_0100, p);
    end

    // Feedback path, including the state right after the first step
    accept(32'h8000_0000, model_scramble(32'h8000_0000, 16'h0000, 16), 16'h0000);
    tick();
    chk("first_step", 64'(dut.r_lfsr), 64'h82F6_3B78);
    wait_result(1);

    // Random matching words, then a random mix
    for (int i = 0; i < 200; i++) begin
      c = $urandom; p = 16'($urandom);
      do_word(c, model_scramble(c, p, 16), p);
    end
    for (int i = 0; i < 20; i++) begin
      c = $urandom; p = 16'($urandom);
      m = model_scramble(c, p, 16);
      d = ($urandom_range(0, 1) == 1) ? (m ^ (32'h1 << $urandom_range(0, 31))) : m;
      do_word(c, d, p);
    end

    // pushin held high: acceptances every 18 cycles, results at 17, 35, 53
    c = $urandom; p = 16'($urandom);
    bus.cand = c; bus.pad_key = p; bus.din = model_scramble(c, p, 16);
    bus.pushin = 1'b1;
    tick();  // E0
    npush = 0;
    for (k = 1; k <= 53; k++) begin
      tick();
      if (bus.pushout) begin
        chk("stream_pos",   64'(k), 64'(17 + 18 * npush));
        chk("stream_match", 64'(bus.match), 64'd1);
        npush++;
      end
    end
    bus.pushin = 1'b0;
    chk("stream_count", 64'(npush), 64'd3);
    tick();

    // Pulses and input changes while busy are ignored
    c = $urandom; p = 16'($urandom);
    d = model_scramble(c, p, 16) ^ 32'h8000_0000;
    accept(c, d, p);
    npush = 0; first = -1;
    for (k = 1; k <= 40; k++) begin
      if (k <= 17) begin
        bus.pushin  = 1'($urandom_range(0, 1));
        bus.din     = $urandom;
        bus.cand    = $urandom;
        bus.pad_key = 16'($urandom);
      end else begin
        bus.pushin = 1'b0;
      end
      tick();
      if (bus.pushout) begin
        npush++;
        first = k;
        if (!exp_match) begin
          err_exp  = (err_exp  < 65535) ? err_exp + 1  : err_exp;
          err2_exp = (err2_exp < 3)     ? err2_exp + 1 : err2_exp;
        end
        chk("busy_match", 64'(bus.match), 64'(exp_match));
        chk("busy_err",   64'(bus.err_cnt), 64'(err_exp));
      end
    end
    chk("busy_count", 64'(npush), 64'd1);
    chk("busy_pos",   64'(first), 64'd17);

    // A matching word so match=1 before the reset test
    c = $urandom; p = 16'($urandom);
    do_word(c, model_scramble(c, p, 16), p);

    // Asynchronous reset during step 8
    c = $urandom; p = 16'($urandom);
    accept(c, model_scramble(c, p, 16), p);
    repeat (8) tick();
    #2 rst = 1'b1;
    #1;
    err_exp = 0; err2_exp = 0;
    chk("arst_ready",   64'(bus.ready),    64'd1);
    chk("arst_pushout", 64'(bus.pushout),  64'd0);
    chk("arst_match",   64'(bus.match),    64'd0);
    chk("arst_err",     64'(bus.err_cnt),  64'd0);
    chk("arst_err2",    64'(bus2.err_cnt), 64'd0);
    tick();
    rst = 1'b0;
    npush = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.pushout) npush++;
    end
    chk("arst_no_pushout", 64'(npush), 64'd0);
    c = $urandom; p = 16'($urandom);
    do_word(c, model_scramble(c, p, 16), p);
    do_word(c, model_scramble(c, p, 16) ^ 32'h0000_0001, p);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_scramble_checker
`default_nettype wire
